// File: rtl/fmul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fmul_share_arbiter
// Description : Shares one multi-cycle single-precision multiplier among NREQ
//               requesters. Round-robin grant, one operation in flight, and
//               the result is held for the owning requester until accepted.
//               Optional build macro: FMUL_ARB_TIMEOUT_EN adds a watchdog in
//               WAIT. On expiry it substitutes a quiet NaN with rsp_err=1.
// Ports       : clk, reset           - clock / synchronous active-high reset
//               req_valid/ready/a/b  - per-requester operand handshake
//               rsp_valid/ready/z/err- per-requester result handshake
//               grant_id, busy       - current owner / operation pending
//               mul_start/a/b        - issue side to the shared multiplier
//               mul_done/z           - completion side from the multiplier
// Revision    : 1.0 - initial release
// ============================================================================
module fmul_share_arbiter #(
  parameter int NREQ           = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [31:0]        rsp_z,
  output logic               rsp_err,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               mul_start,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  input  logic               mul_done,
  input  logic [31:0]        mul_z
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     z_q, z_d;
  logic [NREQ-1:0] rspv_q, rspv_d;

  logic            w_found;
  logic [IDW-1:0]  w_gnt;

`ifdef FMUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  // Keeps the watchdog parameter referenced when the feature is compiled out.
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // Round-robin search: first requesting index after the last winner.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gnt   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    rspv_d  = rspv_q;
`ifdef FMUL_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      c_IDLE: begin
        if (w_found) begin
          a_d     = req_a[32*int'(w_gnt) +: 32];
          b_d     = req_b[32*int'(w_gnt) +: 32];
          grant_d = w_gnt;
          ptr_d   = w_gnt;
          busy_d  = 1'b1;
          state_d = c_ISSUE;
        end
      end
      c_ISSUE: begin
`ifdef FMUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = c_WAIT;
      end
      c_WAIT: begin
        // A completion in the limit cycle takes priority over the watchdog.
        if (mul_done) begin
          z_d     = mul_z;
          rspv_d  = NREQ'(1) << grant_q;
          state_d = c_RESP;
`ifdef FMUL_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          z_d     = 32'h7FC0_0000;
          err_d   = 1'b1;
          rspv_d  = NREQ'(1) << grant_q;
          state_d = c_RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
`endif
        end
      end
      c_RESP: begin
        // Only the owner's rsp_ready releases the result.
        if (rsp_ready[grant_q]) begin
          rspv_d  = '0;
          busy_d  = 1'b0;
          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      rspv_q  <= '0;
`ifdef FMUL_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      rspv_q  <= rspv_d;
`ifdef FMUL_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign req_ready = (state_q == c_IDLE && w_found) ? (NREQ'(1) << w_gnt) : '0;
  assign mul_start = (state_q == c_ISSUE);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rsp_valid = rspv_q;
  assign rsp_z     = z_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
`ifdef FMUL_ARB_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fmul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmul_share_arbiter
// Description : Directed plus randomized bench for fmul_share_arbiter. A
//               stand-in multiplier answers after a chosen latency. A
//               round-robin model predicts owners, operands, results, timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmul_share_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  rsp_z, mul_a, mul_b, mul_z, mdl_z;
  logic         rsp_err, busy, mul_start, mul_done, mdl_done, stray_done;
  logic [1:0]   grant_id;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [31:0] op_a [4];
  logic [31:0] op_b [4];
  int rr_last;

  int mdl_lat = 5;
  bit mdl_never = 1'b0;

  always #5 clk = ~clk;

  // A stray completion carries a bogus product so that capturing it shows up.
  assign mul_done = mdl_done | stray_done;
  assign mul_z    = stray_done ? 32'hDEAD_BEEF : mdl_z;

  fmul_share_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .grant_id(grant_id), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_z(mul_z)
  );

  // Stand-in multiplier product: exact for 2.0*3.0, otherwise a distinctive
  // mix of the operands so that any routing error changes the value.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
  endfunction

  // Round-robin rule: first valid index after the previous winner.
  function automatic int next_grant(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Stand-in multiplier: done pulses L cycles after the start cycle.
  initial begin
    int cd;
    bit pend;
    logic [31:0] ma, mb;
    cd = 0; pend = 1'b0; ma = '0; mb = '0;
    mdl_done = 1'b0;
    mdl_z = '0;
    forever begin
      @(posedge clk);
      #1;
      mdl_done = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cd--;
          if (cd == 0) begin
            mdl_done = 1'b1;
            mdl_z    = ref_mul(ma, mb);
            pend     = 1'b0;
          end
        end
        if (mul_start && !mdl_never) begin
          pend = 1'b1;
          cd   = mdl_lat;
          ma   = mul_a;
          mb   = mul_b;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops(input int i);
    req_a[32*i +: 32] = op_a[i];
    req_b[32*i +: 32] = op_b[i];
  endtask

  // One complete transaction for the owner the model predicts.
  task automatic run_op(input int L, input int hold, input bit stray,
                        input bit exp_to, output int g);
    int n, lat;
    logic [31:0] ea, eb, ez;
    g = next_grant(req_valid, rr_last);
    mdl_lat = L;
    #1;
    n = 0;
    while (req_ready == 4'b0 && n < 20) begin tick(); n++; end
    chk("accept_in_time", 32'(n < 20), 32'd1);
    chk("req_ready_onehot", 32'(req_ready), 32'(4'b1 << g));
    ea = op_a[g];
    eb = op_b[g];
    ez = exp_to ? 32'h7FC0_0000 : ref_mul(ea, eb);
    rr_last = g;
    tick();
    chk("mul_start_issue", 32'(mul_start), 32'd1);
    chk("mul_a", mul_a, ea);
    chk("mul_b", mul_b, eb);
    chk("grant_id", 32'(grant_id), 32'(g));
    chk("busy_issue", 32'(busy), 32'd1);
    chk("req_ready_issue", 32'(req_ready), 32'd0);
    if (stray) stray_done = 1'b1;
    op_a[g] = $urandom;
    op_b[g] = $urandom;
    drive_ops(g);
    tick();
    stray_done = 1'b0;
    lat = 2;
    chk("mul_start_single", 32'(mul_start), 32'd0);
    while (rsp_valid == 4'b0 && lat < L + 12) begin tick(); lat++; end
    chk("rsp_latency", 32'(lat), 32'(L + 2));
    chk("rsp_valid_onehot", 32'(rsp_valid), 32'(4'b1 << g));
    chk("rsp_z", rsp_z, ez);
    chk("rsp_err", 32'(rsp_err), 32'(exp_to));
    for (int h = 0; h < hold; h++) begin
      rsp_ready = ~(4'b1 << g);
      req_valid = 4'b1111;
      tick();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'(4'b1 << g));
      chk("hold_rsp_z", rsp_z, ez);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 4'b1 << g;
    tick();
    rsp_ready = 4'b0;
    chk("rsp_cleared", 32'(rsp_valid), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);
  endtask

  initial begin
    int g, n;
    reset      = 1'b1;
    req_valid  = 4'b0;
    rsp_ready  = 4'b0;
    stray_done = 1'b0;
    req_a      = '0;
    req_b      = '0;
    rr_last    = 3;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = $urandom;
      op_b[i] = $urandom;
      drive_ops(i);
    end
    tick(); tick(); tick();

    // Reset state
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_z", rsp_z, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    reset = 1'b0;
    tick();

    // Single op 2.0 * 3.0 from requester 0
    op_a[0] = 32'h4000_0000;
    op_b[0] = 32'h4040_0000;
    drive_ops(0);
    req_valid = 4'b0001;
    run_op(5, 0, 1'b0, 1'b0, g);
    req_valid = 4'b0;
    tick();

    // All requesters valid: rotation over eight operations
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      run_op(int'($urandom_range(1, 8)), 0, 1'b0, 1'b0, g);
    end
    req_valid = 4'b0;
    tick();

    // Backpressure on requester 2 with all others requesting
    req_valid = 4'b0100;
    run_op(3, 10, 1'b0, 1'b0, g);
    req_valid = 4'b0;
    tick();

    // Reset while waiting on the multiplier
    req_valid = 4'b0100;
    mdl_lat = 10;
    #1;
    n = 0;
    while (req_ready == 4'b0 && n < 20) begin tick(); n++; end
    chk("rstwait_accept", 32'(req_ready), 32'b0100);
    tick(); tick(); tick();
    reset = 1'b1;
    req_valid = 4'b0;
    tick();
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_z", rsp_z, 32'd0);
    chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
    chk("midrst_grant_id", 32'(grant_id), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mul_start", 32'(mul_start), 32'd0);
    chk("midrst_mul_a", mul_a, 32'd0);
    chk("midrst_mul_b", mul_b, 32'd0);
    reset = 1'b0;
    rr_last = 3;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req_valid = 4'b1111;
    run_op(2, 0, 1'b0, 1'b0, g);
    req_valid = 4'b0;
    tick();

`ifdef FMUL_ARB_TIMEOUT_EN
    // Multiplier never answers: watchdog substitutes a quiet NaN
    req_valid = 4'b1000;
    mdl_never = 1'b1;
    run_op(64, 0, 1'b0, 1'b1, g);
    mdl_never = 1'b0;
    req_valid = 4'b0;
    tick();
`endif

    // Stray completions in IDLE and ISSUE are ignored
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    chk("stray_idle_rsp", 32'(rsp_valid), 32'd0);
    chk("stray_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("stray_idle_rsp2", 32'(rsp_valid), 32'd0);
    req_valid = 4'b0010;
    run_op(4, 0, 1'b1, 1'b0, g);
    req_valid = 4'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
